// File: rtl/btn_event_array.sv
// NUM_BTN-channel push-button front end: synchroniser, polarity mapping and debounce FSM per
// channel, with press/release pulses and a clean level. Optional auto-repeat via BTN_AUTOREPEAT_EN.
module btn_event_array #(
    parameter int unsigned NUM_BTN      = 2,
    parameter int unsigned NUM_SYNC     = 2,
    parameter int unsigned DEBOUNCE     = 16,
    parameter int unsigned BTN_ACTIVE   = 0,
    parameter int unsigned REPEAT_DELAY = 64,
    parameter int unsigned REPEAT_RATE  = 16
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [NUM_BTN-1:0] btn_i,
    output logic [NUM_BTN-1:0] level_o,
    output logic [NUM_BTN-1:0] press_o,
    output logic [NUM_BTN-1:0] release_o,
    output logic               any_press_o
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE - 1);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HELD = 1'b1
    } state_e;

    if (NUM_BTN < 1 || NUM_SYNC < 2 || DEBOUNCE < 1 || REPEAT_DELAY < 1 || REPEAT_RATE < 1)
    begin : g_bad_cfg
        $error("btn_event_array: illegal parameter set");
    end

    logic [NUM_BTN-1:0] active;

    // Polarity is normalised before the first synchroniser stage.
    assign active = (BTN_ACTIVE != 0) ? btn_i : ~btn_i;

    for (genvar n = 0; n < NUM_BTN; n++) begin : g_ch
        logic [NUM_SYNC-1:0] sync_q, sync_d;
        logic                s;
        state_e              state_q, state_d;
        logic [CNT_W-1:0]    cnt_q, cnt_d;
        logic                press_q, press_d;
        logic                release_q, release_d;

`ifdef BTN_AUTOREPEAT_EN
        localparam int unsigned REP_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
        localparam int unsigned REP_W   = $clog2(REP_MAX + 1);
        localparam logic [REP_W-1:0] REP_DELAY_LAST = REP_W'(REPEAT_DELAY - 1);
        localparam logic [REP_W-1:0] REP_RATE_LAST  = REP_W'(REPEAT_RATE - 1);

        logic [REP_W-1:0] rep_cnt_q, rep_cnt_d;
        logic             rep_run_q, rep_run_d;
        logic [REP_W-1:0] rep_target;

        // First repeat waits REPEAT_DELAY, later ones REPEAT_RATE.
        assign rep_target = rep_run_q ? REP_RATE_LAST : REP_DELAY_LAST;
`endif

        assign sync_d = {sync_q[NUM_SYNC-2:0], active[n]};
        assign s      = sync_q[NUM_SYNC-1];

        // Debounce next-state: a sample disagreeing with the current state extends the run,
        // an agreeing sample restarts it.
        always_comb begin
            state_d   = state_q;
            cnt_d     = cnt_q;
            press_d   = 1'b0;
            release_d = 1'b0;
`ifdef BTN_AUTOREPEAT_EN
            rep_cnt_d = rep_cnt_q;
            rep_run_d = rep_run_q;
`endif
            if (state_q == ST_IDLE) begin
`ifdef BTN_AUTOREPEAT_EN
                rep_cnt_d = '0;
                rep_run_d = 1'b0;
`endif
                if (s) begin
                    if (cnt_q == CNT_LAST) begin
                        state_d = ST_HELD;
                        press_d = 1'b1;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end else begin
                    cnt_d = '0;
                end
            end else begin
                if (!s) begin
`ifdef BTN_AUTOREPEAT_EN
                    rep_cnt_d = '0;
                    rep_run_d = 1'b0;
`endif
                    if (cnt_q == CNT_LAST) begin
                        state_d   = ST_IDLE;
                        release_d = 1'b1;
                        cnt_d     = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end else begin
                    cnt_d = '0;
`ifdef BTN_AUTOREPEAT_EN
                    if (rep_cnt_q == rep_target) begin
                        press_d   = 1'b1;
                        rep_cnt_d = '0;
                        rep_run_d = 1'b1;
                    end else begin
                        rep_cnt_d = rep_cnt_q + REP_W'(1);
                    end
`endif
                end
            end
        end

        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                sync_q    <= '0;
                state_q   <= ST_IDLE;
                cnt_q     <= '0;
                press_q   <= 1'b0;
                release_q <= 1'b0;
`ifdef BTN_AUTOREPEAT_EN
                rep_cnt_q <= '0;
                rep_run_q <= 1'b0;
`endif
            end else begin
                sync_q    <= sync_d;
                state_q   <= state_d;
                cnt_q     <= cnt_d;
                press_q   <= press_d;
                release_q <= release_d;
`ifdef BTN_AUTOREPEAT_EN
                rep_cnt_q <= rep_cnt_d;
                rep_run_q <= rep_run_d;
`endif
            end
        end

        assign level_o[n]   = (state_q == ST_HELD);
        assign press_o[n]   = press_q;
        assign release_o[n] = release_q;
    end

    assign any_press_o = |press_o;

endmodule

// File: tb/tb_btn_event_array.sv
// Randomised and directed bench for btn_event_array against a run-length reference model.
module tb_btn_event_array;

    localparam int unsigned NB = 2;
    localparam int unsigned NS = 2;
    localparam int unsigned DB = 4;
    localparam int unsigned BA = 0;
    localparam int unsigned RD = 10;
    localparam int unsigned RR = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic [NB-1:0] btn;
    logic [NB-1:0] level_o, press_o, release_o;
    logic          any_press_o;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    btn_event_array #(
        .NUM_BTN(NB), .NUM_SYNC(NS), .DEBOUNCE(DB), .BTN_ACTIVE(BA),
        .REPEAT_DELAY(RD), .REPEAT_RATE(RR)
    ) dut (
        .clk_i(clk), .rst_i(rst), .btn_i(btn),
        .level_o(level_o), .press_o(press_o), .release_o(release_o),
        .any_press_o(any_press_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Reference model: pin delayed through the synchroniser, then run lengths of samples
    // disagreeing with the accepted level decide press/release; held run length gives repeats.
    logic [NS-1:0] m_hist [NB];
    int            m_run  [NB];
    int            m_hold [NB];
    logic [NB-1:0] m_level, m_press, m_rel;
    logic          m_s, m_a;

    always @(posedge clk) begin
        for (int n = 0; n < NB; n++) begin
            if (rst) begin
                m_hist[n]  = '0;
                m_run[n]   = 0;
                m_hold[n]  = 0;
                m_level[n] = 1'b0;
                m_press[n] = 1'b0;
                m_rel[n]   = 1'b0;
            end else begin
                m_s        = m_hist[n][NS-1];
                m_a        = (BA != 0) ? btn[n] : ~btn[n];
                m_hist[n]  = {m_hist[n][NS-2:0], m_a};
                m_press[n] = 1'b0;
                m_rel[n]   = 1'b0;
                if (m_s != m_level[n]) begin
                    m_run[n]++;
                    m_hold[n] = 0;
                    if (m_run[n] == DB) begin
                        m_level[n] = m_s;
                        m_press[n] = m_s;
                        m_rel[n]   = ~m_s;
                        m_run[n]   = 0;
                    end
                end else begin
                    m_run[n] = 0;
                    if (m_level[n]) begin
                        m_hold[n]++;
`ifdef BTN_AUTOREPEAT_EN
                        if (m_hold[n] >= RD && ((m_hold[n] - RD) % RR) == 0)
                            m_press[n] = 1'b1;
`endif
                    end
                end
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                check("model_level",   32'(level_o),     32'(m_level));
                check("model_press",   32'(press_o),     32'(m_press));
                check("model_release", 32'(release_o),   32'(m_rel));
                check("model_any",     32'(any_press_o), 32'(|m_press));
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    int cnt_p, cnt_r;
    int seg_len [NB];
    logic exp_rep;

    initial begin
        rst = 1'b1;
        btn = 2'b11;
        @(posedge clk);
        chk_en = 1'b1;
        #2;

        // Reset with inactive pins
        for (int i = 0; i < 4; i++) begin
            step(1);
            check("rst_outputs", 32'({level_o, press_o, release_o, any_press_o}), 32'd0);
        end
        rst = 1'b0;
        cnt_p = 0;
        cnt_r = 0;
        for (int i = 0; i < 10; i++) begin
            step(1);
            cnt_p += int'(press_o != 0);
            cnt_r += int'(release_o != 0);
        end
        check("post_rst_events", 32'(cnt_p + cnt_r), 32'd0);
        check("post_rst_level", 32'(level_o), 32'd0);

        // Clean press then release on channel 0
        btn = 2'b10;
        step(5);
        check("press_early", 32'(press_o), 32'd0);
        step(1);
        check("press_edge6", 32'(press_o), 32'b01);
        check("press_any", 32'(any_press_o), 32'd1);
        step(1);
        check("press_single", 32'(press_o), 32'd0);
        check("press_level", 32'(level_o), 32'b01);
        btn = 2'b11;
        step(5);
        check("rel_early", 32'(release_o), 32'd0);
        step(1);
        check("rel_edge6", 32'(release_o), 32'b01);
        check("rel_level", 32'(level_o), 32'b00);
        step(1);
        check("rel_single", 32'(release_o), 32'd0);

        // Bounce with period 3, then stable active
        cnt_p = 0;
        cnt_r = 0;
        for (int i = 0; i < 13; i++) begin
            btn[0] = (i % 2 == 0) ? 1'b1 : 1'b0;
            for (int k = 0; k < 3; k++) begin
                step(1);
                cnt_p += int'(press_o[0]);
                cnt_r += int'(release_o[0]);
            end
        end
        check("bounce_no_event", 32'(cnt_p + cnt_r), 32'd0);
        btn[0] = 1'b0;
        step(5);
        check("bounce_early", 32'(press_o), 32'd0);
        step(1);
        check("bounce_press", 32'(press_o), 32'b01);
        btn = 2'b11;
        step(8);

        // Simultaneous press on both channels
        btn = 2'b00;
        step(6);
        check("simul_press", 32'(press_o), 32'b11);
        check("simul_any", 32'(any_press_o), 32'd1);
        step(1);
        check("simul_any_off", 32'(any_press_o), 32'd0);
        check("simul_level", 32'(level_o), 32'b11);
        btn = 2'b11;
        step(8);
        check("simul_released", 32'(level_o), 32'b00);

        // Reset while channel 0 is held
        btn = 2'b10;
        step(8);
        check("hold_level", 32'(level_o), 32'b01);
        rst = 1'b1;
        step(1);
        check("midrst_level", 32'(level_o), 32'd0);
        check("midrst_release", 32'(release_o), 32'd0);
        rst = 1'b0;
        cnt_p = 0;
        cnt_r = 0;
        for (int i = 0; i < 5; i++) begin
            step(1);
            cnt_p += int'(press_o[0]);
            cnt_r += int'(release_o[0]);
        end
        check("midrst_quiet", 32'(cnt_p + cnt_r), 32'd0);
        step(1);
        check("midrst_repress", 32'(press_o), 32'b01);
        btn = 2'b11;
        step(8);

        // Long hold: repeats at 10,15,20,25,30 only when auto-repeat is built in
        btn = 2'b10;
        step(6);
        check("rep_first", 32'(press_o), 32'b01);
        for (int k = 1; k <= 30; k++) begin
            step(1);
`ifdef BTN_AUTOREPEAT_EN
            exp_rep = (k >= 10 && (k % 5) == 0);
`else
            exp_rep = 1'b0;
`endif
            check("rep_pulse", 32'(press_o[0]), 32'(exp_rep));
        end
        btn = 2'b11;
        cnt_p = 0;
        cnt_r = 0;
        for (int i = 0; i < 10; i++) begin
            step(1);
            cnt_p += int'(press_o[0]);
            cnt_r += int'(release_o[0]);
        end
        check("rep_after_release", 32'(cnt_p), 32'd0);
        check("rep_release_cnt", 32'(cnt_r), 32'd1);

        // Random segments per channel with occasional reset
        for (int n = 0; n < NB; n++) seg_len[n] = 0;
        for (int c = 0; c < 4000; c++) begin
            for (int n = 0; n < NB; n++) begin
                if (seg_len[n] == 0) begin
                    btn[n]     = 1'($urandom_range(0, 1));
                    seg_len[n] = int'($urandom_range(1, 40));
                end
                seg_len[n]--;
            end
            rst = ($urandom_range(0, 399) == 0);
            step(1);
        end
        rst = 1'b0;
        step(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
